// File: rtl/procb_buf.sv
// procb_buf: per-thread circular buffers of process_bytes records.
// Lookup presents the next record without consuming it; commit frees it.
module procb_buf #(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int DEPTH         = 4,
  parameter int DEPTH_MSB     = $clog2(DEPTH) - 1,
  parameter int D_WIDTH       = 50
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [N_THREADS_MSB:0] wr_thread_num,
  input  logic                   wr_en,
  input  logic [D_WIDTH-1:0]     din,
  output logic                   wr_full,
  input  logic [N_THREADS_MSB:0] rd_thread_num,
  input  logic                   lookup_en,
  input  logic                   rd_en,
  input  logic                   rd_rst,
  output logic                   lookup_empty,
  output logic [D_WIDTH-1:0]     dout,
  output logic [N_THREADS-1:0]   thread_empty,
  output logic [1:0]             err
);
  localparam int PW = DEPTH_MSB + 2;
  localparam int SW = DEPTH_MSB + 1;
  localparam int TW = N_THREADS_MSB + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [D_WIDTH-1:0] mem [N_THREADS*DEPTH];

  logic [PW-1:0] wr_ptr [N_THREADS];
  logic [PW-1:0] rd_ptr [N_THREADS];

  logic          la_q, la_d;
  logic [TW-1:0] prev_thread_q, prev_thread_d;
  logic [1:0]    err_q, err_d;

  logic [PW-1:0] wr_cnt;
  logic [PW-1:0] rd_cnt;
  logic [SW-1:0] head_slot;
  logic [SW-1:0] wr_slot;
  logic          flush_same;
  logic          wr_accept;
  logic          wr_drop;
  logic          commit;
  logic          rd_err;
  logic          thread_switch;

  always_comb begin
    wr_cnt    = wr_ptr[wr_thread_num] - rd_ptr[wr_thread_num];
    rd_cnt    = wr_ptr[rd_thread_num] - rd_ptr[rd_thread_num];
    head_slot = rd_ptr[rd_thread_num][SW-1:0] + SW'(la_q);
  end

  assign wr_full       = (wr_cnt == DEPTH_P);
  assign lookup_empty  = (rd_cnt <= PW'(la_q));
  assign dout          = mem[{rd_thread_num, head_slot}];
  assign thread_switch = (rd_thread_num != prev_thread_q);

  // A flush of the write target frees the buffer, so the write lands in slot 0.
  assign flush_same = rd_rst && (wr_thread_num == rd_thread_num);
  assign wr_accept  = wr_en && (flush_same || !wr_full);
  assign wr_drop    = wr_en && !wr_accept;
  assign wr_slot    = flush_same ? '0 : wr_ptr[wr_thread_num][SW-1:0];

  // Read-side control: commit decision, lookahead update and underflow flag.
  always_comb begin
    commit        = 1'b0;
    rd_err        = 1'b0;
    la_d          = la_q;
    prev_thread_d = rd_thread_num;
    if (rd_rst) begin
      la_d = 1'b0;
    end else begin
      if (lookup_en && rd_en) begin
        if (!lookup_empty) begin
          commit = 1'b1;
        end else begin
          rd_err = 1'b1;
          if (rd_cnt != '0) begin
            commit = 1'b1;
            la_d   = 1'b0;
          end
        end
      end else if (lookup_en) begin
        if (!lookup_empty && !la_q) begin
          la_d = 1'b1;
        end else begin
          rd_err = 1'b1;
        end
      end else if (rd_en) begin
        if (rd_cnt != '0) begin
          commit = 1'b1;
          la_d   = 1'b0;
        end else begin
          rd_err = 1'b1;
        end
      end
      if (thread_switch) begin
        la_d = 1'b0;
      end
    end
    err_d = err_q | {rd_err, wr_drop};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      la_q          <= 1'b0;
      prev_thread_q <= '0;
      err_q         <= '0;
    end else begin
      la_q          <= la_d;
      prev_thread_q <= prev_thread_d;
      err_q         <= err_d;
    end
  end

  assign err = err_q;

  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      mem[{wr_thread_num, wr_slot}] <= din;
    end
  end

  generate
    for (genvar gi = 0; gi < N_THREADS; gi++) begin : g_thread
      logic [PW-1:0] wr_ptr_q, wr_ptr_d;
      logic [PW-1:0] rd_ptr_q, rd_ptr_d;
      logic [PW-1:0] wr_base;
      logic          thread_empty_q, thread_empty_d;
      logic          flush_me;
      logic          wr_me;
      logic          rd_me;

      always_comb begin
        flush_me = rd_rst && (rd_thread_num == TW'(gi));
        wr_me    = wr_accept && (wr_thread_num == TW'(gi));
        rd_me    = commit && (rd_thread_num == TW'(gi));
        wr_base  = flush_me ? '0 : wr_ptr_q;
        wr_ptr_d = wr_me ? wr_base + PW'(1) : wr_base;
        if (flush_me) begin
          rd_ptr_d = '0;
        end else if (rd_me) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
        thread_empty_d = (wr_ptr_d == rd_ptr_d);
      end

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          wr_ptr_q       <= '0;
          rd_ptr_q       <= '0;
          thread_empty_q <= 1'b1;
        end else begin
          wr_ptr_q       <= wr_ptr_d;
          rd_ptr_q       <= rd_ptr_d;
          thread_empty_q <= thread_empty_d;
        end
      end

      assign wr_ptr[gi]       = wr_ptr_q;
      assign rd_ptr[gi]       = rd_ptr_q;
      assign thread_empty[gi] = thread_empty_q;
    end
  endgenerate

endmodule

// File: tb/tb_procb_buf.sv
// Testbench for procb_buf: per-thread record queues as reference model,
// expected outputs queued by the driver and compared by a negedge monitor.
module tb_procb_buf;
  localparam int NT    = 16;
  localparam int DEPTH = 4;
  localparam int DW    = 50;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [3:0]    wr_thread_num = '0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr_full;
  logic [3:0]    rd_thread_num = '0;
  logic          lookup_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          rd_rst = 1'b0;
  logic          lookup_empty;
  logic [DW-1:0] dout;
  logic [NT-1:0] thread_empty;
  logic [1:0]    err;

  always #5 CLK = ~CLK;

  procb_buf #(.N_THREADS(NT), .DEPTH(DEPTH), .D_WIDTH(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .wr_thread_num(wr_thread_num), .wr_en(wr_en), .din(din), .wr_full(wr_full),
    .rd_thread_num(rd_thread_num), .lookup_en(lookup_en), .rd_en(rd_en),
    .rd_rst(rd_rst), .lookup_empty(lookup_empty), .dout(dout),
    .thread_empty(thread_empty), .err(err)
  );

  typedef struct {
    logic          wf;
    logic          le;
    logic          chk_d;
    logic [DW-1:0] d;
    logic [NT-1:0] te;
    logic [1:0]    err;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] mq [NT][$];
  int            la_m = 0;
  int            prev_m = 0;
  logic [1:0]    err_m = 2'b00;
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_txn = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] a, input logic [15:0] len,
                                       input logic fin, input logic stp);
    return {a, len, fin, stp};
  endfunction

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d rd_t=%0d wr_t=%0d lookup_empty=%b dout=%h err=%b",
               n_txn, rd_thread_num, wr_thread_num, lookup_empty, dout, err);
      chk("wr_full", 64'(wr_full), 64'(mon_e.wf));
      chk("lookup_empty", 64'(lookup_empty), 64'(mon_e.le));
      if (mon_e.chk_d) chk("dout", 64'(dout), 64'(mon_e.d));
      chk("thread_empty", 64'(thread_empty), 64'(mon_e.te));
      chk("err", 64'(err), 64'(mon_e.err));
    end
  end

  task automatic step(input int wt, input bit we, input logic [DW-1:0] d,
                      input int rt, input bit le, input bit re, input bit rr);
    exp_t e;
    int   cnt;
    int   wcnt;
    bit   commit;
    int   la_n;
    bit   e1;
    wr_thread_num = 4'(wt);
    wr_en         = we;
    din           = d;
    rd_thread_num = 4'(rt);
    lookup_en     = le;
    rd_en         = re;
    rd_rst        = rr;
    cnt  = mq[rt].size();
    wcnt = mq[wt].size();
    e.wf    = (wcnt == DEPTH);
    e.le    = (cnt <= la_m);
    e.chk_d = !e.le;
    e.d     = e.chk_d ? mq[rt][la_m] : '0;
    for (int t = 0; t < NT; t++) e.te[t] = (mq[t].size() == 0);
    e.err = err_m;
    exp_q.push_back(e);
    @(posedge CLK);
    commit = 0;
    e1     = 0;
    la_n   = la_m;
    if (rr) begin
      la_n = 0;
    end else begin
      if (le && re) begin
        if (cnt > la_m) commit = 1;
        else begin
          e1 = 1;
          if (cnt > 0) begin commit = 1; la_n = la_m - 1; end
        end
      end else if (le) begin
        if (cnt > la_m && la_m == 0) la_n = 1;
        else e1 = 1;
      end else if (re) begin
        if (cnt > 0) begin commit = 1; if (la_m > 0) la_n = la_m - 1; end
        else e1 = 1;
      end
      if (rt != prev_m) la_n = 0;
    end
    if (rr) mq[rt].delete();
    else if (commit) void'(mq[rt].pop_front());
    if (we) begin
      if (rr && wt == rt) mq[wt].push_back(d);
      else if (wcnt == DEPTH) err_m[0] = 1'b1;
      else mq[wt].push_back(d);
    end
    if (e1) err_m[1] = 1'b1;
    la_m   = la_n;
    prev_m = rt;
    #1;
  endtask

  task automatic mid_reset(input int rt);
    wr_en = 0; lookup_en = 0; rd_en = 0; rd_rst = 0;
    rd_thread_num = 4'(rt);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_lookup_empty", 64'(lookup_empty), 64'(1));
    chk("rst_thread_empty", 64'(thread_empty), 64'({NT{1'b1}}));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_wr_full", 64'(wr_full), 64'(0));
    for (int t = 0; t < NT; t++) mq[t].delete();
    la_m = 0; prev_m = 0; err_m = 2'b00;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

  initial begin : drive
    logic [DW-1:0] ra, rb, rc, rr_d;
    int wt, rt_cur;
    ra = mk(32'h10, 16'd5, 1'b0, 1'b0);
    rb = mk(32'h20, 16'd8, 1'b1, 1'b0);
    rc = mk(32'h30, 16'd3, 1'b0, 1'b1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    step(0, 0, '0, 0, 0, 0, 0);           // reset state
    step(3, 1, ra, 3, 0, 0, 0);
    step(3, 1, rb, 3, 0, 0, 0);
    step(0, 0, '0, 3, 0, 0, 0);           // dout = A
    step(0, 0, '0, 3, 1, 0, 0);           // lookup
    step(0, 0, '0, 3, 0, 1, 0);           // dout = B, commit A
    step(0, 0, '0, 3, 1, 0, 0);           // lookup past last record
    step(0, 0, '0, 3, 0, 0, 0);           // lookup_empty
    step(3, 1, rc, 3, 0, 0, 0);
    step(0, 0, '0, 3, 0, 0, 0);           // lookahead shows C
    step(0, 0, '0, 4, 0, 0, 0);           // switch away
    step(0, 0, '0, 3, 0, 0, 0);           // rewound: B
    step(0, 0, '0, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(7, 1, mk(32'h100 + i, 16'(i), 1'b0, 1'b0), 3, 0, 0, 0);
    step(7, 0, '0, 7, 0, 0, 0);           // full, err = 01
    step(0, 0, '0, 0, 0, 1, 0);           // commit on empty thread
    step(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(5, 1, mk(32'h200 + i, 16'd1, 1'b1, 1'b1), 0, 0, 0, 0);
    step(5, 0, '0, 5, 0, 0, 0);
    step(5, 1, rc, 5, 1, 1, 1);           // flush with concurrent write
    step(5, 0, '0, 5, 0, 0, 0);           // count 1, dout = C
    step(2, 1, ra, 2, 0, 0, 0);
    step(2, 1, rb, 2, 0, 0, 0);
    step(2, 0, '0, 2, 0, 0, 0);
    mid_reset(2);
    step(2, 0, '0, 2, 0, 0, 0);
    rt_cur = 0;
    for (int i = 0; i < 3000; i++) begin
      wt = ($urandom_range(7) == 0) ? int'($urandom_range(NT - 1)) : int'($urandom_range(3));
      if ($urandom_range(9) < 2) rt_cur = ($urandom_range(7) == 0) ? int'($urandom_range(NT - 1))
                                                                   : int'($urandom_range(3));
      rr_d = DW'({$urandom(), $urandom()});
      step(wt, ($urandom_range(1) == 1), rr_d, rt_cur,
           ($urandom_range(99) < 35), ($urandom_range(99) < 30), ($urandom_range(49) == 0));
    end
    wr_en = 0; lookup_en = 0; rd_en = 0; rd_rst = 0;
    @(negedge CLK);
    #1;
    chk("drain", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/procb_buf.md
Name: procb_buf

Overview:
- Per-thread store of process_bytes (procb) records, one circular buffer per thread.
- Write port: CPU-side command parser pushes a record (address, byte count, finish_ctx, stop_ctx) into a thread's buffer.
- Read port: lookup/commit interface serving the procb-consuming scheduler.
- Lookup shows the next record without consuming it; commit frees it; uncommitted lookups rewind on thread switch.

Parameters:
- N_THREADS, 16, number of threads (power of 2).
- N_THREADS_MSB, `MSB(N_THREADS-1), thread number MSB.
- DEPTH, 4, records per thread (power of 2, min 2).
- DEPTH_MSB, `MSB(DEPTH-1), slot index MSB.
- D_WIDTH, `PROCB_D_WIDTH, record width.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  asynchronous, active-low reset.
- wr_thread_num  in  N_THREADS_MSB+1  target thread for write.
- wr_en  in  1  push din into the wr_thread_num buffer.
- din  in  D_WIDTH  record {addr, bytes_left, finish_ctx, stop_ctx}.
- wr_full  out  1  buffer of wr_thread_num is full (combinational).
- rd_thread_num  in  N_THREADS_MSB+1  thread being served.
- lookup_en  in  1  advance lookahead past the presented record.
- rd_en  in  1  commit (free) oldest record of rd_thread_num.
- rd_rst  in  1  flush rd_thread_num buffer.
- lookup_empty  out  1  no record available at lookahead position (combinational).
- dout  out  D_WIDTH  record at lookahead position (combinational, async RAM read).
- thread_empty  out  N_THREADS  registered per-thread "no records" flags.
- err  out  2  sticky: [0] write overflow, [1] commit/lookup underflow.

Behaviour:
- Storage: distributed RAM, N_THREADS*DEPTH x D_WIDTH; address {thread, slot}.
- Per thread: wr_ptr and rd_ptr, DEPTH_MSB+2 bits each (slot + wrap bit); count = wr_ptr - rd_ptr, range 0..DEPTH.
- Single global lookahead la in {0,1}; head h = rd_ptr[rd_thread_num] + la.
- Reset (RESET_N=0, async):
  - all ptrs 0, la 0, err 0, thread_empty all 1.
  - wr_full=0, lookup_empty=1.
  - RAM contents undefined; dout undefined (not checked).
- Write:
  - wr_en & count<DEPTH: mem[wr_thread,wr_ptr slot]<=din; wr_ptr++.
  - wr_en & full: data dropped, err[0]<=1.
  - wr_full = (count[wr_thread_num]==DEPTH).
- Read outputs:
  - dout = mem[rd_thread_num, h slot].
  - lookup_empty = (count[rd_thread_num] <= la).
- lookup_en:
  - If !lookup_empty, la<=1.
  - If lookup_empty, or la already 1 without concurrent rd_en: no change, err[1]<=1.
- rd_en:
  - If count>0: rd_ptr++; la<=la-1 (saturate at 0).
  - If count==0: ignored, err[1]<=1.
- lookup_en & rd_en in the same cycle: rd_ptr++, la unchanged (net: next record presented). Requires count>=2 when la=1; otherwise err[1]<=1 and only rd_en takes effect.
- Rewind: la<=0 in any cycle where rd_thread_num differs from its previous-cycle value (prev value registered; reset value 0). Rewind has priority over lookup_en in that cycle.
- rd_rst:
  - Flushes rd_thread_num: rd_ptr<=0, wr_ptr<=0, la<=0.
  - Overrides rd_en/lookup_en that cycle; no err.
  - Concurrent wr_en to the same thread is accepted: record written to slot 0, wr_ptr<=1.
  - Writes to other threads unaffected.
- Simultaneous wr_en and rd_en on the same thread:
  - Both take effect; full check uses pre-cycle count.
  - Hence a write to a full buffer while committing is dropped (err[0]).
- thread_empty[t] <= (next count[t]==0), registered, 1-cycle latency.
- Pointers wrap modulo 2*DEPTH; the slot index is the low DEPTH_MSB+1 bits.
- Latency: write visible on dout/lookup_empty the cycle after wr_en.

Test Plan:
- Reset, then write thread 3 records A,B (A=addr 0x10, len 5, fin 0) -> next cycle with rd_thread_num=3: lookup_empty=0, dout=A, thread_empty[3]=0.
- lookup_en at t, rd_en at t+1 -> dout=B at t+1; at t+2 count=1, lookup_empty=1 after a second lookup.
- lookup_en, then switch rd_thread_num 3->4->3 without rd_en -> dout=A again; rd_ptr unchanged.
- Write 5 records to thread 7 (DEPTH=4) -> wr_full=1 after the 4th; 5th dropped; err=2'b01.
- rd_en on empty thread 0 -> no pointer change, err[1]=1. Then rd_rst on thread 5 with 3 records plus concurrent wr_en C to thread 5 -> count=1, dout=C.
- Assert RESET_N=0 mid-stream with 2 records in thread 2 -> immediately lookup_empty=1, thread_empty=all 1, err=0.
